alu64_reg: RTL and testbench

// - Registered integer ALU for the datapath execute stage: combines operands a/b per a 4-bit

---
 rtl/alu64_reg.sv | 90 +++++++++
 tb/tb_alu64_reg.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu64_reg.sv
// Registered integer ALU: one-cycle latency result plus zero/negative/carry/overflow
// status flags and an illegal-opcode indication.
module alu64_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal_op
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   sh_s;
  logic [WIDTH:0]   add_sum_s;
  logic [WIDTH:0]   sub_sum_s;
  logic [WIDTH-1:0] res_nxt_s;
  logic             carry_nxt_s;
  logic             ovf_nxt_s;
  logic             ill_nxt_s;

  assign sh_s = b[SHW-1:0];
  // Subtraction is a + ~b + 1 so bit WIDTH is the inverted borrow.
  assign add_sum_s = {1'b0, a} + {1'b0, b};
  assign sub_sum_s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  // Next-state result and flags decoded from the operation select.
  always_comb begin
    res_nxt_s   = {WIDTH{1'b0}};
    carry_nxt_s = 1'b0;
    ovf_nxt_s   = 1'b0;
    ill_nxt_s   = 1'b0;
    case (alu_control)
      4'b0000: res_nxt_s = a & b;
      4'b0001: res_nxt_s = a | b;
      4'b0010: begin
        res_nxt_s   = add_sum_s[WIDTH-1:0];
        carry_nxt_s = add_sum_s[WIDTH];
        ovf_nxt_s   = (a[WIDTH-1] == b[WIDTH-1]) && (add_sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0011: res_nxt_s = a ^ b;
      4'b0100: res_nxt_s = a << sh_s;
      4'b0101: res_nxt_s = a >> sh_s;
      4'b1101: res_nxt_s = $unsigned($signed(a) >>> sh_s);
      4'b0110: begin
        res_nxt_s   = sub_sum_s[WIDTH-1:0];
        carry_nxt_s = sub_sum_s[WIDTH];
        ovf_nxt_s   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0111: res_nxt_s = b;
      4'b1000: res_nxt_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1001: res_nxt_s = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b1100: res_nxt_s = ~(a | b);
      default: ill_nxt_s = 1'b1;
    endcase
  end

  // Output registers: reset wins over in_valid; without in_valid the flags hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      result     <= {WIDTH{1'b0}};
      zero       <= 1'b0;
      negative   <= 1'b0;
      carry      <= 1'b0;
      overflow   <= 1'b0;
      illegal_op <= 1'b0;
    end else if (in_valid) begin
      out_valid  <= 1'b1;
      result     <= res_nxt_s;
      zero       <= (res_nxt_s == {WIDTH{1'b0}});
      negative   <= res_nxt_s[WIDTH-1];
      carry      <= carry_nxt_s;
      overflow   <= ovf_nxt_s;
      illegal_op <= ill_nxt_s;
    end else begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu64_reg.sv
// Self-checking bench for alu64_reg: directed vectors, hold/reset control and
// randomized traffic against an arithmetic reference model.
module tb_alu64_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] a = 64'd0;
  logic [63:0] b = 64'd0;
  logic [3:0]  alu_control = 4'd0;
  logic        out_valid;
  logic [63:0] result;
  logic        zero, negative, carry, overflow, illegal_op;

  int checks = 0;
  int errors = 0;
  // Expected architectural state {result, zero, negative, carry, overflow, illegal_op}.
  logic [68:0] held = 69'd0;

  alu64_reg #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .alu_control(alu_control), .out_valid(out_valid), .result(result),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  wire [69:0] obs = {result, zero, negative, carry, overflow, illegal_op, out_valid};

  // Reference model from the arithmetic definitions, not the gate structure.
  function automatic logic [68:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic [3:0] op);
    logic [63:0] r;
    logic c, v, ill;
    longint sx, sy;
    logic signed [65:0] w;
    int sh;
    r = 64'd0; c = 1'b0; v = 1'b0; ill = 1'b0;
    sx = x; sy = y;
    sh = int'(y[5:0]);
    case (op)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2: begin
        r = x + y;
        c = (r < x);
        w = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y});
        v = (w != $signed({{2{r[63]}}, r}));
      end
      4'd3:  r = x ^ y;
      4'd4:  r = x << sh;
      4'd5:  r = x >> sh;
      4'd13: r = 64'(sx >>> sh);
      4'd6: begin
        r = x - y;
        c = (x >= y);
        w = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y});
        v = (w != $signed({{2{r[63]}}, r}));
      end
      4'd7:  r = y;
      4'd8:  r = (sx < sy) ? 64'd1 : 64'd0;
      4'd9:  r = (x < y) ? 64'd1 : 64'd0;
      4'd12: r = ~(x | y);
      default: ill = 1'b1;
    endcase
    return {r, (r == 64'd0), r[63], c, v, ill};
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'hFFFF_FFFF_FFFF_FFFF;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'd0;
      4: return 64'(unsigned'($urandom_range(0, 130)));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic drive(input logic [63:0] x, input logic [63:0] y, input logic [3:0] op,
                       input logic v, input logic rst);
    @(negedge clk);
    a = x; b = y; alu_control = op; in_valid = v; rst_n = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 1'b1, 1'b0);
    drive(64'd5, 64'd7, 4'b1111, 1'b1, 1'b0);
    held = 69'd0;
    checks++;
    if (obs !== 70'd0) begin
      errors++;
      $display("FAIL reset: got %h exp %h", obs, 70'd0);
    end
  endtask

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
    logic [3:0]  op;
    logic [63:0] r;
  } vec_t;

  task automatic test_directed();
    vec_t t[$];
    logic [68:0] e;
    t.push_back('{64'd1915, 64'd1402, 4'b0010, 64'd3317});
    t.push_back('{64'h5F5B, 64'hC8D6, 4'b0000, 64'h4852});
    t.push_back('{64'h5F5B, 64'hC8D6, 4'b0001, 64'hDFDF});
    t.push_back('{64'h5F5B, 64'hC8D6, 4'b1100, ~64'hDFDF});
    t.push_back('{64'd1915, 64'd1402, 4'b0110, 64'd513});
    t.push_back('{64'd1402, 64'd1402, 4'b0110, 64'd0});
    t.push_back('{64'd0, 64'd1, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF});
    t.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'h8000_0000_0000_0000});
    t.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'd0});
    t.push_back('{64'h8000_0000_0000_0001, 64'd65, 4'b0100, 64'h2});
    t.push_back('{64'h8000_0000_0000_0001, 64'd65, 4'b0101, 64'h4000_0000_0000_0000});
    t.push_back('{64'h8000_0000_0000_0001, 64'd65, 4'b1101, 64'hC000_0000_0000_0000});
    t.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1000, 64'd1});
    t.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1001, 64'd0});
    t.push_back('{64'd123, 64'd456, 4'b1111, 64'd0});
    foreach (t[i]) begin
      drive(t[i].x, t[i].y, t[i].op, 1'b1, 1'b1);
      e = model(t[i].x, t[i].y, t[i].op);
      held = e;
      checks++;
      if (result !== t[i].r) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h exp %h", i, result, t[i].r);
      end
      checks++;
      if (obs !== {e, 1'b1}) begin
        errors++;
        $display("FAIL directed_flags[%0d]: got %h exp %h", i, obs, {e, 1'b1});
      end
    end
    // Spot-check the flag values quoted for the boundary vectors.
    drive(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 1'b1, 1'b1);
    held = model(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010);
    checks++;
    if ({zero, negative, carry, overflow, illegal_op} !== 5'b01010) begin
      errors++;
      $display("FAIL add_ovf_flags: got %b exp %b", {zero, negative, carry, overflow, illegal_op}, 5'b01010);
    end
    drive(64'd1402, 64'd1402, 4'b0110, 1'b1, 1'b1);
    held = model(64'd1402, 64'd1402, 4'b0110);
    checks++;
    if ({zero, negative, carry, overflow, illegal_op} !== 5'b10100) begin
      errors++;
      $display("FAIL sub_zero_flags: got %b exp %b", {zero, negative, carry, overflow, illegal_op}, 5'b10100);
    end
  endtask

  task automatic test_hold();
    drive(64'd1915, 64'd1402, 4'b0110, 1'b1, 1'b1);
    held = model(64'd1915, 64'd1402, 4'b0110);
    for (int i = 0; i < 3; i++) begin
      drive({$urandom, $urandom}, {$urandom, $urandom}, 4'(i), 1'b0, 1'b1);
      checks++;
      if (obs !== {held, 1'b0}) begin
        errors++;
        $display("FAIL hold[%0d]: got %h exp %h", i, obs, {held, 1'b0});
      end
    end
  endtask

  task automatic test_reset_inflight();
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 4'b0001, 1'b1, 1'b1);
    drive(64'd3, 64'd4, 4'b0010, 1'b1, 1'b0);
    held = 69'd0;
    checks++;
    if (obs !== 70'd0) begin
      errors++;
      $display("FAIL reset_inflight: got %h exp %h", obs, 70'd0);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] x, y;
    logic [3:0] op;
    for (int i = 0; i < 200; i++) begin
      x = pick(); y = pick(); op = 4'($urandom_range(0, 15));
      drive(x, y, op, 1'b1, 1'b1);
      held = model(x, y, op);
      checks++;
      if (obs !== {held, 1'b1}) begin
        errors++;
        $display("FAIL back_to_back[%0d] op=%h a=%h b=%h: got %h exp %h", i, op, x, y, obs, {held, 1'b1});
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] x, y;
    logic [3:0] op;
    logic v;
    for (int i = 0; i < 300; i++) begin
      x = pick(); y = pick(); op = 4'($urandom_range(0, 15));
      v = ($urandom_range(0, 3) != 0);
      drive(x, y, op, v, 1'b1);
      if (v) held = model(x, y, op);
      checks++;
      if (obs !== {held, v}) begin
        errors++;
        $display("FAIL random[%0d] op=%h v=%b: got %h exp %h", i, op, v, obs, {held, v});
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_inflight();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
